// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority voting,
// glitch-rejecting start detection, optional parity, error pulses, valid/ready output.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS);
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
    localparam logic [CW-1:0] CNT_RES  = CW'(HALF + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  samp0_q, samp0_d, samp1_q, samp1_d;
    logic                  par_err_q, par_err_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic                  overrun_q, overrun_d;

    logic rxd_s, maj, at_wrap, at_res, par_expect;

    assign rxd_s      = sync2_q;
    assign maj        = (samp0_q & samp1_q) | (samp0_q & rxd_s) | (samp1_q & rxd_s);
    assign at_wrap    = (cnt_q == CNT_LAST);
    assign at_res     = (cnt_q == CNT_RES);
    assign par_expect = (PARITY == 2) ? ~^shift_q : ^shift_q;

    always_comb begin
        state_d      = state_q;
        sync1_d      = rxd;
        sync2_d      = sync1_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        samp0_d      = samp0_q;
        samp1_d      = samp1_q;
        par_err_d    = par_err_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (state_q != S_IDLE) begin
            cnt_d = at_wrap ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_S0) samp0_d = rxd_s;
            if (cnt_q == CNT_S1) samp1_d = rxd_s;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxd_s) state_d = S_START;
            end
            S_START: begin
                // A start bit that votes high at mid-bit was only a glitch.
                if (at_res && maj) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (at_wrap) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (at_res) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (at_wrap) begin
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (at_res)  par_err_d = (maj != par_expect);
                if (at_wrap) state_d   = S_STOP;
            end
            S_STOP: begin
                // Finish at mid stop bit so the next start edge is never missed.
                if (at_res) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (!maj) begin
                        frame_err_d = 1'b1;
                    end else if ((PARITY != 0) && par_err_q) begin
                        parity_err_d = 1'b1;
                    end else if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            samp0_q      <= 1'b1;
            samp1_q      <= 1'b1;
            par_err_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            samp0_q      <= samp0_d;
            samp1_q      <= samp1_d;
            par_err_q    <= par_err_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance (channel 0) and an even-parity instance (channel 1),
// both at 16 clocks per bit, checked against a frame-level reference model.
module tb_uart_rx_param;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    localparam int K_LOAD  = 0;
    localparam int K_FRAME = 1;
    localparam int K_PAR   = 2;
    localparam int K_OVR   = 3;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic [1:0] rxd_w      = 2'b11;
    logic [1:0] rx_ready_w = 2'b11;
    wire  [15:0] rx_data_w;
    wire  [1:0]  rx_valid_w, frame_err_w, parity_err_w, overrun_w, busy_w;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_t0  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0)) dut_a (
        .clk(clk), .reset(reset), .rxd(rxd_w[0]),
        .rx_data(rx_data_w[7:0]), .rx_valid(rx_valid_w[0]), .rx_ready(rx_ready_w[0]),
        .frame_err(frame_err_w[0]), .parity_err(parity_err_w[0]),
        .overrun(overrun_w[0]), .busy(busy_w[0])
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1)) dut_b (
        .clk(clk), .reset(reset), .rxd(rxd_w[1]),
        .rx_data(rx_data_w[15:8]), .rx_valid(rx_valid_w[1]), .rx_ready(rx_ready_w[1]),
        .frame_err(frame_err_w[1]), .parity_err(parity_err_w[1]),
        .overrun(overrun_w[1]), .busy(busy_w[1])
    );

    // Completion events observed on the outputs
    typedef struct {
        int         ch;
        int         cyc;
        int         kind;
        logic [7:0] data;
        logic       busy;
    } evt_t;

    evt_t evq[$];
    logic [1:0] pv = 2'b00;
    logic [1:0] pr = 2'b00;

    function automatic void log_evt(input int c, input int kind);
        evt_t e;
        e.ch   = c;
        e.cyc  = cyc;
        e.kind = kind;
        e.data = rx_data_w[c*8 +: 8];
        e.busy = busy_w[c];
        evq.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                if (rx_valid_w[c] && (!pv[c] || pr[c])) log_evt(c, K_LOAD);
                if (frame_err_w[c])  log_evt(c, K_FRAME);
                if (parity_err_w[c]) log_evt(c, K_PAR);
                if (overrun_w[c])    log_evt(c, K_OVR);
            end
        end
        pv <= rx_valid_w;
        pr <= rx_ready_w;
    end

    // Reference model: outcome of a frame from the line-level rules
    function automatic int ref_outcome(input int ch, input logic [7:0] data, input int pbit,
                                       input logic stop_v, input logic held, input logic ready);
        if (!stop_v) return K_FRAME;
        if (ch == 1 && pbit != ($countones(data) % 2)) return K_PAR;
        if (!held || ready) return K_LOAD;
        return K_OVR;
    endfunction

    // Edges from the first start-bit drive cycle to the completion edge
    function automatic int lat(input int ch);
        return 3 + (9 + ch) * CPB + HALF + 2;
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_LOAD:  return "load";
            K_FRAME: return "frame_err";
            K_PAR:   return "parity_err";
            K_OVR:   return "overrun";
            default: return "none";
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic expect_evt(input string name, input int ch, input int kind,
                              input logic [7:0] data, input int at);
        evt_t e;
        checks++;
        if (evq.size() == 0) begin
            failures++;
            $display("FAIL %s: no completion seen, required ch=%0d %s data=%02h at cycle %0d",
                     name, ch, kname(kind), data, at);
        end else begin
            e = evq.pop_front();
            if (e.ch != ch || e.kind != kind || e.cyc != at || e.busy !== 1'b0 ||
                (kind == K_LOAD && e.data !== data)) begin
                failures++;
                $display("FAIL %s: got ch=%0d %s data=%02h cycle=%0d busy=%b, required ch=%0d %s data=%02h cycle=%0d busy=0",
                         name, e.ch, kname(e.kind), e.data, e.cyc, e.busy,
                         ch, kname(kind), data, at);
            end else begin
                $display("ok   %s: ch=%0d %s data=%02h cycle=%0d", name, ch, kname(kind), e.data, e.cyc);
            end
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d unexpected outputs, first ch=%0d %s at cycle %0d, required none",
                     name, evq.size(), evq[0].ch, kname(evq[0].kind), evq[0].cyc);
            evq.delete();
        end else begin
            $display("ok   %s: no unexpected outputs", name);
        end
    endtask

    // Drives one frame; pbit used only on channel 1; glitch_at inverts one cycle;
    // rdy_pulse_at raises rx_ready for exactly one cycle at that drive offset.
    task automatic send_frame(input int ch, input logic [7:0] data, input int pbit,
                              input logic stop_v, input int glitch_at, input int rdy_pulse_at);
        logic bits[$];
        logic v;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (ch == 1) bits.push_back(pbit[0]);
        bits.push_back(stop_v);
        for (int i = 0; i < bits.size() * CPB; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) last_t0 = cyc;
            v = bits[i / CPB];
            if (i == glitch_at) v = ~v;
            rxd_w[ch] = v;
            if (rdy_pulse_at >= 0 && i == rdy_pulse_at) rx_ready_w[ch] = 1'b1;
            else if (rdy_pulse_at >= 0 && i == rdy_pulse_at + 1) rx_ready_w[ch] = 1'b0;
        end
        if (!stop_v) begin
            @(posedge clk);
            #1;
            rxd_w[ch] = 1'b1;
            repeat (2 * CPB) @(posedge clk);
        end
    endtask

    typedef struct {
        int         ch;
        logic [7:0] data;
        int         pbit;
        logic       stop_v;
        int         glitch_at;
        int         kind;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[12];
    int   busy_cnt;
    int   t;

    initial begin
        vecs[0]  = '{0, 8'hA5, 0, 1'b1, -1,                 K_LOAD,  8'hA5};
        vecs[1]  = '{1, 8'h55, 0, 1'b1, -1,                 K_LOAD,  8'h55};
        vecs[2]  = '{1, 8'h55, 1, 1'b1, -1,                 K_PAR,   8'h00};
        vecs[3]  = '{0, 8'h00, 0, 1'b1, 4 * CPB + HALF + 1, K_LOAD,  8'h00};
        vecs[4]  = '{0, 8'h3C, 0, 1'b0, -1,                 K_FRAME, 8'h00};
        vecs[5]  = '{0, 8'h3C, 0, 1'b1, -1,                 K_LOAD,  8'h3C};
        vecs[6]  = '{0, 8'hFF, 0, 1'b1, -1,                 K_LOAD,  8'hFF};
        vecs[7]  = '{0, 8'h01, 0, 1'b1, 2 * CPB + HALF,     K_LOAD,  8'h01};
        vecs[8]  = '{1, 8'h80, 1, 1'b1, -1,                 K_LOAD,  8'h80};
        vecs[9]  = '{1, 8'h80, 0, 1'b1, -1,                 K_PAR,   8'h00};
        vecs[10] = '{1, 8'h3C, 1, 1'b0, -1,                 K_FRAME, 8'h00};
        vecs[11] = '{1, 8'hFE, 1, 1'b1, CPB + HALF + 2,     K_LOAD,  8'hFE};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset rx_valid", 32'(rx_valid_w), 32'h0);
        chk("reset flags", 32'({frame_err_w, parity_err_w, overrun_w}), 32'h0);
        chk("reset busy", 32'(busy_w), 32'h0);
        chk("reset rx_data", 32'(rx_data_w), 32'h0);
        reset = 1'b0;
        busy_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy_w != 2'b00) busy_cnt++;
        end
        chk("no false start after reset", 32'(busy_cnt), 32'h0);

        // Table-driven frames with rx_ready held high
        for (int i = 0; i < 12; i++) begin
            send_frame(vecs[i].ch, vecs[i].data, vecs[i].pbit, vecs[i].stop_v, vecs[i].glitch_at, -1);
            expect_evt($sformatf("vec%0d", i), vecs[i].ch, vecs[i].kind, vecs[i].exp_data,
                       last_t0 + lat(vecs[i].ch));
            repeat (3) @(posedge clk);
        end
        check_quiet("table tail");

        // Short low pulse: start entered then abandoned
        @(posedge clk);
        #1;
        t = cyc;
        rxd_w[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd_w[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("glitch start busy high", 32'(busy_w[0]), 32'h1);
        while (cyc < t + 15) @(negedge clk);
        chk("glitch start busy dropped", 32'(busy_w[0]), 32'h0);
        check_quiet("glitch start no outputs");

        // Overrun and same-edge consume/load with rx_ready low
        @(posedge clk);
        #1;
        rx_ready_w[0] = 1'b0;
        send_frame(0, 8'h11, 0, 1'b1, -1, -1);
        expect_evt("hold 0x11", 0, ref_outcome(0, 8'h11, 0, 1'b1, 1'b0, 1'b0), 8'h11, last_t0 + lat(0));
        send_frame(0, 8'h22, 0, 1'b1, -1, -1);
        expect_evt("overrun 0x22", 0, ref_outcome(0, 8'h22, 0, 1'b1, 1'b1, 1'b0), 8'h00, last_t0 + lat(0));
        chk("held rx_data", 32'(rx_data_w[7:0]), 32'h11);
        chk("held rx_valid", 32'(rx_valid_w[0]), 32'h1);
        send_frame(0, 8'h33, 0, 1'b1, -1, lat(0) - 1);
        expect_evt("consume+load 0x33", 0, ref_outcome(0, 8'h33, 0, 1'b1, 1'b1, 1'b1), 8'h33, last_t0 + lat(0));
        chk("after load rx_data", 32'(rx_data_w[7:0]), 32'h33);
        chk("after load rx_valid", 32'(rx_valid_w[0]), 32'h1);
        check_quiet("overrun sequence");

        // Reset during data bit 4; line stays high afterwards
        fork
            send_frame(0, 8'h99, 0, 1'b1, -1, -1);
            begin
                repeat (88) @(posedge clk);
                #2;
                chk("pre-reset busy", 32'(busy_w[0]), 32'h1);
                chk("pre-reset rx_valid", 32'(rx_valid_w[0]), 32'h1);
                reset = 1'b1;
                #1;
                chk("mid-frame reset rx_valid", 32'(rx_valid_w), 32'h0);
                chk("mid-frame reset rx_data", 32'(rx_data_w), 32'h0);
                chk("mid-frame reset busy", 32'(busy_w), 32'h0);
                chk("mid-frame reset flags", 32'({frame_err_w, parity_err_w, overrun_w}), 32'h0);
            end
        join
        @(posedge clk);
        #1;
        reset = 1'b0;
        rx_ready_w = 2'b11;
        repeat (20) @(posedge clk);
        check_quiet("aborted frame");
        send_frame(0, 8'h7E, 0, 1'b1, -1, -1);
        expect_evt("after reset 0x7E", 0, K_LOAD, 8'h7E, last_t0 + lat(0));

        // Randomized frames against the reference model
        for (int n = 0; n < 40; n++) begin
            int         ch, pbit, g, k;
            logic [7:0] d;
            logic       s;
            ch   = int'($urandom_range(0, 1));
            d    = 8'($urandom);
            s    = ($urandom_range(0, 7) != 0);
            pbit = ($countones(d) % 2) ^ int'($urandom_range(0, 3) == 0);
            g    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(CPB, (9 + ch) * CPB - 1)) : -1;
            k    = ref_outcome(ch, d, pbit, s, 1'b0, 1'b1);
            send_frame(ch, d, pbit, s, g, -1);
            expect_evt($sformatf("rand%0d", n), ch, k, (k == K_LOAD) ? d : 8'h00, last_t0 + lat(ch));
            repeat (int'($urandom_range(0, 6))) @(posedge clk);
        end
        repeat (5) @(posedge clk);
        check_quiet("random tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the Phaethon serial link, replacing the fixed 8N1 receiver. It adds configurable bit period, data width and parity, a 2-flop input synchroniser, 3-sample majority voting, glitch-rejecting start detection, error reporting, and a valid/ready output register. It sits between the board RXD pin and the host-command front end.

## Interface
- CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200); legal range >= 8.
- DATA_BITS, default 8: data bits per frame; legal range 5..9.
- PARITY, default 0: 0 = none, 1 = even, 2 = odd.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- rxd  in  1  raw serial line, idle high, asynchronous to clk.
- rx_data  out  DATA_BITS  received word, LSB first on the line.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready at a rising edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch (PARITY != 0).
- overrun  out  1  one-cycle pulse: good word dropped because the output register was full.
- busy  out  1  high whenever state != IDLE.

## Operation
- Reset values: rx_data = 0, rx_valid = 0, frame_err = parity_err = overrun = 0, busy = 0, state IDLE, counter 0, bit index 0. Both synchroniser flops reset to 1, so no false start after reset.
- rxd passes through 2 flops; rxd_s is the second flop's output. All logic uses rxd_s only.
- HALF = CLKS_PER_BIT/2 (integer division). Counter width is $clog2(CLKS_PER_BIT).
- Bit sampling: rxd_s is sampled at counter HALF-1, HALF and HALF+1 of each bit period. The bit value is the 2-of-3 majority, resolved at counter HALF+1.
- Counter runs 0..CLKS_PER_BIT-1 and wraps to 0 at the end of each bit period.
- IDLE: if rxd_s == 0, go to START with counter = 0.
- START: if the majority at HALF+1 is 1, go to IDLE (glitch rejected; no flags, no output). Otherwise, at counter wrap, go to DATA with bit index 0.
- DATA: each resolved bit shifts into a shift register LSB first. After bit DATA_BITS-1 wraps, go to PARITY if PARITY != 0, else go to STOP.
- PARITY: the resolved bit is compared with the XOR of the data bits. Even mode expects the XOR value; odd mode expects its inverse. The mismatch is recorded; at wrap, go to STOP.
- STOP: at HALF+1 (not at wrap) resolve the stop bit and go to IDLE in that same edge. This resyncs early so back-to-back frames are tolerated.
- Completion, evaluated in priority order:
  - Stop bit 0: pulse frame_err; word discarded; parity_err not asserted.
  - Parity mismatch: pulse parity_err; word discarded.
  - Output register free, or being consumed this same edge: load rx_data, set rx_valid = 1.
  - Otherwise: pulse overrun; new word dropped; old rx_data and rx_valid unchanged.
- Handshake: rx_valid clears on the edge where rx_valid && rx_ready, unless a word loads on that same edge; then rx_valid stays 1 with the new data and no overrun.
- rx_data is stable while rx_valid = 1 and no handshake occurs.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is lost.

## Timing
- Let E be the rising edge at which the state goes IDLE -> START. rxd low reaches rxd_s 2 edges after the first flop samples it.
- START counter = 0 in the cycle after E. The stop bit begins (1 + DATA_BITS + P) * CLKS_PER_BIT cycles after E, where P = 1 if PARITY != 0.
- rx_valid, frame_err, parity_err and overrun change on edge E + (1 + DATA_BITS + P) * CLKS_PER_BIT + HALF + 2.
- Error pulses are exactly 1 cycle wide.
- busy falls on that same edge. A new START can be entered 1 cycle later.
- Throughput: one word per (2 + DATA_BITS + P) * CLKS_PER_BIT cycles minimum. The sender's clock may be fast by up to HALF - 2 cycles per frame.

## Test plan
- CLKS_PER_BIT = 16, 8N1, rx_ready = 1: send 0xA5 -> rx_valid for 1 cycle with rx_data = 0xA5 at E + 9*16 + 10; no flags.
- PARITY = 1 (even): send 0x55 with parity bit 0 -> word delivered. Send 0x55 with parity bit 1 -> parity_err 1-cycle pulse, rx_valid stays 0.
- Drive rxd low for 4 cycles, then high -> START entered and abandoned, busy drops, no outputs. Also flip 1 cycle of the middle sample window of bit 3 of 0x00 -> rx_data = 0x00 (majority vote).
- Stop bit held low on 0x3C -> frame_err pulse, rx_valid 0; next correct frame 0x3C is received normally.
- rx_ready = 0, send 0x11 then 0x22 back-to-back -> rx_data = 0x11, rx_valid = 1, overrun pulse on the second completion. Raise rx_ready on the completion edge of a third frame 0x33 -> rx_data = 0x33, rx_valid stays 1, no overrun.
- Assert reset during DATA bit 4 -> all outputs 0 immediately. After release with rxd high, the next frame 0x7E is received correctly.
